ssi_selftest_ctrl: RTL

Sequencer that drives the 15-bit IN bus of the SSI gate library top level (AND, OR, NOT, NAND, NOR, XOR, XNOR, tri-state buffer) through its four 2-bit input patterns. After a settle delay it samples the 8-bit OUT bus and compares it against internally generated expected values. It accumulates a per-gate error mask and reports pass/fail through a start/busy/done handshake. It sits between board switches/buttons (or a bench) and the gate library instance.

---
 rtl/ssi_pkg.sv | 69 ++++++
 rtl/ssi_selftest_ctrl_if.sv | 24 ++
 rtl/ssi_golden.sv | 16 +
 rtl/ssi_selftest_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ssi_pkg.sv
// Shared types and helpers for the SSI gate-library self-test sequencer:
// FSM states, IN-bus pair offsets, OUT-bus gate indices and the reference model.
package ssi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Low bit position of each gate's input field on the 15-bit IN bus
  localparam int unsigned OFS_AND  = 0;
  localparam int unsigned OFS_OR   = 2;
  localparam int unsigned OFS_NOT  = 4;
  localparam int unsigned OFS_NAND = 5;
  localparam int unsigned OFS_NOR  = 7;
  localparam int unsigned OFS_XOR  = 9;
  localparam int unsigned OFS_XNOR = 11;
  localparam int unsigned OFS_TRI  = 13;

  localparam int unsigned G_AND  = 0;
  localparam int unsigned G_OR   = 1;
  localparam int unsigned G_NOT  = 2;
  localparam int unsigned G_NAND = 3;
  localparam int unsigned G_NOR  = 4;
  localparam int unsigned G_XOR  = 5;
  localparam int unsigned G_XNOR = 6;
  localparam int unsigned G_TRI  = 7;

  function automatic logic [14:0] pattern_bus(input logic [1:0] p);
    logic [14:0] bus;
    bus                = 15'd0;
    bus[OFS_AND  +: 2] = p;
    bus[OFS_OR   +: 2] = p;
    bus[OFS_NOT]       = p[0];
    bus[OFS_NAND +: 2] = p;
    bus[OFS_NOR  +: 2] = p;
    bus[OFS_XOR  +: 2] = p;
    bus[OFS_XNOR +: 2] = p;
    // TRI field is {enable, data}
    bus[OFS_TRI  +: 2] = p;
    return bus;
  endfunction

  // Returns {mask, expected}; the tri-state bit is only compared when enabled
  function automatic logic [15:0] exp_out(input logic [1:0] p);
    logic       a;
    logic       b;
    logic [7:0] e;
    logic [7:0] m;
    a         = p[1];
    b         = p[0];
    e         = 8'd0;
    e[G_AND]  = a & b;
    e[G_OR]   = a | b;
    e[G_NOT]  = ~b;
    e[G_NAND] = ~(a & b);
    e[G_NOR]  = ~(a | b);
    e[G_XOR]  = a ^ b;
    e[G_XNOR] = ~(a ^ b);
    e[G_TRI]  = a & b;
    m         = 8'h7F;
    m[G_TRI]  = a;
    return {m, e};
  endfunction

endpackage

// File: rtl/ssi_selftest_ctrl_if.sv
// Handshake and gate-library bus bundle between the self-test sequencer
// (master) and the switches/bench plus library instance (slave).
interface ssi_selftest_ctrl_if;
  logic        START;
  logic        CONT;
  logic [14:0] DUT_IN;
  logic [7:0]  DUT_OUT;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [7:0]  ERR_MASK;
  logic [2:0]  FAIL_CNT;
  logic [1:0]  PAT;

  modport master (
    input  START, CONT, DUT_OUT,
    output DUT_IN, BUSY, DONE, PASS, ERR_MASK, FAIL_CNT, PAT
  );

  modport slave (
    output START, CONT, DUT_OUT,
    input  DUT_IN, BUSY, DONE, PASS, ERR_MASK, FAIL_CNT, PAT
  );
endinterface

// File: rtl/ssi_golden.sv
// Combinational expected-value and compare-mask generator for one input
// pattern of the SSI gate library.
module ssi_golden
  import ssi_pkg::*;
(
  input  logic [1:0] pat,
  output logic [7:0] exp_val,
  output logic [7:0] mask
);

  // Expected OUT bus and compare mask for the current pattern
  always_comb begin
    {mask, exp_val} = exp_out(pat);
  end

endmodule

// File: rtl/ssi_selftest_ctrl.sv
// Self-test sequencer: sweeps the four input patterns through the gate
// library, checks OUT after a settle delay and reports per-gate errors.
module ssi_selftest_ctrl
  import ssi_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic        CONT_DEFAULT  = 1'b0
) (
  input logic                  CLK,
  input logic                  RST_n,
  ssi_selftest_ctrl_if.master  bus
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  pat_q, pat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        start_prev_q, start_prev_d;
  logic        cont_q, cont_d;
  logic [14:0] dut_in_q, dut_in_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_mask_q, err_mask_d;
  logic [2:0]  fail_cnt_q, fail_cnt_d;
  logic [7:0]  exp_s, mask_s, diff_s;

  ssi_golden u_golden (
    .pat     (pat_q),
    .exp_val (exp_s),
    .mask    (mask_s)
  );

  assign diff_s = (bus.DUT_OUT ^ exp_s) & mask_s;

  // Next-state and next-output logic of the sweep sequencer
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    cnt_d        = cnt_q;
    start_prev_d = bus.START;
    cont_d       = cont_q;
    dut_in_d     = dut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_mask_d   = err_mask_q;
    fail_cnt_d   = fail_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.START && !start_prev_q) begin
          err_mask_d = 8'h00;
          fail_cnt_d = 3'd0;
          pass_d     = 1'b0;
          pat_d      = 2'd0;
          cont_d     = bus.CONT;
          busy_d     = 1'b1;
          state_d    = ST_DRIVE;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        dut_in_d = pattern_bus(pat_q);
        cnt_d    = CNT_LOAD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        err_mask_d = err_mask_q | diff_s;
        fail_cnt_d = fail_cnt_q + {2'b00, |diff_s};
        if (pat_q == 2'd3) begin
          // PASS includes the final pattern's result, so it uses err_mask_d
          done_d  = 1'b1;
          pass_d  = (err_mask_d == 8'h00);
          state_d = ST_DONE;
        end else begin
          pat_d   = pat_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: begin
        if (cont_q && bus.START) begin
          err_mask_d = 8'h00;
          fail_cnt_d = 3'd0;
          pat_d      = 2'd0;
          state_d    = ST_DRIVE;
        end else begin
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q      <= ST_IDLE;
      pat_q        <= 2'd0;
      cnt_q        <= 4'd0;
      start_prev_q <= 1'b0;
      cont_q       <= CONT_DEFAULT;
      dut_in_q     <= 15'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_mask_q   <= 8'h00;
      fail_cnt_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_prev_d;
      cont_q       <= cont_d;
      dut_in_q     <= dut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_mask_q   <= err_mask_d;
      fail_cnt_q   <= fail_cnt_d;
    end
  end

  assign bus.DUT_IN   = dut_in_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.PASS     = pass_q;
  assign bus.ERR_MASK = err_mask_q;
  assign bus.FAIL_CNT = fail_cnt_q;
  assign bus.PAT      = pat_q;

endmodule
